// File: rtl/dimmer_pkg.sv
// dimmer_pkg
// Shared definitions for the pwm_dimmer_fsm lamp dimmer.
//   BTN_UP / BTN_DOWN / BTN_OFF : bit positions of the buttons on i_button
//   level_cmd_e                 : resolved per-cycle command driving the level FSM
//   level_width()               : width of the level register for a given level count
//   level_duty()                : elaboration-time duty value for brightness level k
package dimmer_pkg;

  localparam int N_BTN    = 3;
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_OFF  = 2;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2,
    CMD_OFF  = 2'd3
  } level_cmd_e;

  // Width needed to hold levels 0..levels-1, never narrower than one bit.
  function automatic int level_width(input int levels);
    return (levels > 2) ? $clog2(levels) : 1;
  endfunction

  // Duty for level k spreads the levels evenly over the full PWM scale,
  // rounding down, so level 0 is 0 and the top level is all ones.
  function automatic int level_duty(input int k, input int pwmBits, input int levels);
    longint fullScale;
    fullScale = (longint'(1) << pwmBits) - longint'(1);
    return int'((longint'(k) * fullScale) / longint'(levels - 1));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchroniser, debounce counter and press-pulse generator for one
// raw active-high button.
//   i_clk    : system clock
//   i_reset  : synchronous active-low reset
//   i_btn    : raw asynchronous button input
//   o_press  : one-cycle pulse when the debounced state goes released->pressed
// The debounced state changes only after DEBOUNCE_CYCLES consecutive cycles in
// which the synchronised input disagrees with it. The pulse is registered one
// cycle after the debounced rise, giving DEBOUNCE_CYCLES+2 cycles from the
// first sampled high to o_press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          stablePrev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          press_q;
  logic          press_d;

  // Count disagreeing cycles; any agreeing cycle clears the count, and the
  // last disagreeing cycle flips the debounced state and restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = stable_q & ~stablePrev_q;
  end

  // Synchroniser, debounce state and edge-detect registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= i_btn;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/pwm_dimmer_fsm.sv
// pwm_dimmer_fsm
// Three-button lamp dimmer: debounced up/down/off buttons step a saturating
// brightness level, which selects the duty of a single PWM output.
//   i_clk       : system clock
//   i_reset     : synchronous active-low reset
//   i_button    : raw buttons, active high, [0]=up [1]=down [2]=off
//   o_pwm_light : registered PWM lamp drive
//   o_level     : current target brightness level (0 = off)
//   o_period    : one-cycle pulse on the tick where the PWM counter wraps
// Optional feature macro PWM_DIMMER_FADE_EN: when defined, the active duty
// slews toward the target by at most FADE_STEP per PWM period; otherwise it
// jumps straight to the target at the next period boundary.
module pwm_dimmer_fsm
  import dimmer_pkg::*;
#(
  parameter int CLK_DIV         = 100,
  parameter int PWM_BITS        = 10,
  parameter int LEVELS          = 5,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int FADE_STEP       = 8,
  localparam int LW             = level_width(LEVELS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [2:0]    i_button,
  output logic          o_pwm_light,
  output logic [LW-1:0] o_level,
  output logic          o_period
);

  localparam int PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PSW-1:0]      PRESC_LAST = PSW'(CLK_DIV - 1);
  localparam logic [LW-1:0]       LEVEL_MAX  = LW'(LEVELS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FULL  = PWM_BITS'(level_duty(LEVELS - 1, PWM_BITS, LEVELS));

  if (CLK_DIV < 1 || PWM_BITS < 1 || LEVELS < 2 || DEBOUNCE_CYCLES < 1 || FADE_STEP < 1) begin : gBadParams
    $error("pwm_dimmer_fsm: parameter out of range");
  end

  logic [N_BTN-1:0]    press;
  level_cmd_e          cmd;
  logic [PSW-1:0]      presc_q;
  logic [PSW-1:0]      presc_d;
  logic                tick;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;
  logic                periodPulse;
  logic [LW-1:0]       level_q;
  logic [LW-1:0]       level_d;
  logic [PWM_BITS-1:0] targetDuty;
  logic [PWM_BITS-1:0] activeDuty_q;
  logic [PWM_BITS-1:0] activeDuty_d;
  logic                pwm_q;
  logic                pwm_d;

  // One debouncer per button; each yields a single-cycle press pulse.
  for (genvar g = 0; g < N_BTN; g++) begin : gBtn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_btn  (i_button[g]),
      .o_press(press[g])
    );
  end

  // Prescaler and PWM counter. The counter wraps naturally from all ones to
  // zero; the wrap tick is the period boundary. o_period is held low while
  // reset is asserted so it never glitches before the first reset edge.
  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    presc_d     = tick ? '0 : presc_q + PSW'(1);
    cnt_d       = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
    periodPulse = tick && (cnt_q == '1) && i_reset;
  end

  // Level FSM: resolve simultaneous presses (off beats down beats up) and
  // step the level with saturation at both ends.
  always_comb begin
    cmd = CMD_NONE;
    if (press[BTN_OFF]) begin
      cmd = CMD_OFF;
    end else if (press[BTN_DOWN]) begin
      cmd = CMD_DOWN;
    end else if (press[BTN_UP]) begin
      cmd = CMD_UP;
    end

    level_d = level_q;
    case (cmd)
      CMD_UP:   if (level_q != LEVEL_MAX) level_d = level_q + LW'(1);
      CMD_DOWN: if (level_q != '0) level_d = level_q - LW'(1);
      CMD_OFF:  level_d = '0;
      default:  level_d = level_q;
    endcase
  end

  // Map the level to its duty through a constant table built at elaboration.
  always_comb begin
    targetDuty = '0;
    for (int k = 0; k < LEVELS; k++) begin
      if (level_q == LW'(k)) begin
        targetDuty = PWM_BITS'(level_duty(k, PWM_BITS, LEVELS));
      end
    end
  end

`ifdef PWM_DIMMER_FADE_EN
  logic [PWM_BITS-1:0] dutyDiff;

  // Fading build: on each period boundary move toward the target by at most
  // FADE_STEP, landing exactly on the target when closer than one step.
  always_comb begin
    activeDuty_d = activeDuty_q;
    dutyDiff     = '0;
    if (periodPulse) begin
      if (targetDuty > activeDuty_q) begin
        dutyDiff     = targetDuty - activeDuty_q;
        activeDuty_d = (int'(dutyDiff) > FADE_STEP) ? activeDuty_q + PWM_BITS'(FADE_STEP) : targetDuty;
      end else if (targetDuty < activeDuty_q) begin
        dutyDiff     = activeDuty_q - targetDuty;
        activeDuty_d = (int'(dutyDiff) > FADE_STEP) ? activeDuty_q - PWM_BITS'(FADE_STEP) : targetDuty;
      end
    end
  end
`else
  // Direct build: the new target takes effect whole at the next period
  // boundary, so a period in progress always finishes with its old duty.
  always_comb begin
    activeDuty_d = activeDuty_q;
    if (periodPulse) begin
      activeDuty_d = targetDuty;
    end
  end
`endif

  // Compare stage. Full scale and zero are forced so the lamp is truly
  // steady at the extremes instead of a one-tick sliver every period.
  always_comb begin
    if (activeDuty_q == DUTY_FULL) begin
      pwm_d = 1'b1;
    end else if (activeDuty_q == '0) begin
      pwm_d = 1'b0;
    end else begin
      pwm_d = (cnt_q < activeDuty_q);
    end
  end

  // State registers for prescaler, counter, level, duty and output.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      level_q      <= '0;
      activeDuty_q <= '0;
      pwm_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      activeDuty_q <= activeDuty_d;
      pwm_q        <= pwm_d;
    end
  end

  assign o_pwm_light = pwm_q;
  assign o_level     = level_q;
  assign o_period    = periodPulse;

endmodule

// File: tb/tb_pwm_dimmer_fsm.sv
// tb_pwm_dimmer_fsm
// Randomised scoreboard bench for pwm_dimmer_fsm. The stimulus side issues
// button commands and queues the level change each one should cause; a
// monitor compares level changes as they fall due and checks the number of
// lit cycles in every PWM period against the duty the level rules predict.
module tb_pwm_dimmer_fsm;

  localparam int CLK_DIV   = 1;
  localparam int PWM_BITS  = 4;
  localparam int LEVELS    = 5;
  localparam int DEB       = 4;
  localparam int FADE_STEP = 4;
  localparam int LW        = 3;
  localparam int PERIOD    = 1 << PWM_BITS;
  localparam int FULL      = PERIOD - 1;

  typedef struct {
    int due;
    int level;
  } levelEvent_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [2:0]    buttons = 3'b000;
  wire           pwmLight;
  wire  [LW-1:0] level;
  wire           periodPulse;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  bit monEn = 1'b0;

  levelEvent_t expQ[$];
  levelEvent_t ev;
  int stimLevel = 0;
  int modelLevel = 0;
  int modelActive = 0;
  int pendingDuty = 0;
  int curDuty = 0;
  int highCnt = 0;
  bit periodSeenLast = 1'b0;
  bit trackValid = 1'b0;
  int lastPeriodCyc = -1;
  int prevLevelSample = 0;

  pwm_dimmer_fsm #(
    .CLK_DIV        (CLK_DIV),
    .PWM_BITS       (PWM_BITS),
    .LEVELS         (LEVELS),
    .DEBOUNCE_CYCLES(DEB),
    .FADE_STEP      (FADE_STEP)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rstN),
    .i_button   (buttons),
    .o_pwm_light(pwmLight),
    .o_level    (level),
    .o_period   (periodPulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Duty of a level: levels spread evenly over 0..FULL, rounded down.
  function automatic int dutyOf(input int k);
    return (k * FULL) / (LEVELS - 1);
  endfunction

  // Lit cycles in one period for a duty; full scale is lit the whole period.
  function automatic int highCountOf(input int d);
    return (d == FULL) ? PERIOD : d;
  endfunction

  function automatic int nextActive(input int active, input int target);
`ifdef PWM_DIMMER_FADE_EN
    if (target > active) return (target - active > FADE_STEP) ? active + FADE_STEP : target;
    if (target < active) return (active - target > FADE_STEP) ? active - FADE_STEP : target;
    return active;
`else
    return target;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one command from a negedge. A clean press is held long enough to
  // debounce and its effect is queued; a bounce never stays high for a full
  // debounce window and must leave the level untouched.
  task automatic applyStimulus(input logic [2:0] mask, input bit bounce, input int gap);
    if (!bounce) begin
      int hold;
      int newLevel;
      hold = $urandom_range(DEB, DEB + 6);
      newLevel = stimLevel;
      if (mask[2]) newLevel = 0;
      else if (mask[1]) newLevel = (stimLevel > 0) ? stimLevel - 1 : 0;
      else if (mask[0]) newLevel = (stimLevel < LEVELS - 1) ? stimLevel + 1 : LEVELS - 1;
      if (newLevel != stimLevel) expQ.push_back('{due: cyc + DEB + 4, level: newLevel});
      stimLevel = newLevel;
      buttons = mask;
      repeat (hold) @(negedge clk);
      buttons = 3'b000;
    end else begin
      for (int r = 0; r < 4; r++) begin
        buttons = mask;
        repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
        buttons = 3'b000;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: level events fall due at a known cycle; each completed PWM
  // period is checked against the duty latched at its start.
  always @(negedge clk) begin
    if (monEn) begin
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        ev = expQ.pop_front();
        modelLevel = ev.level;
        checkOutput("level_update", int'(level), ev.level);
      end else if (int'(level) != prevLevelSample && int'(level) != modelLevel) begin
        checkOutput("unexpected_level_change", int'(level), modelLevel);
      end
      prevLevelSample = int'(level);

      highCnt += int'(pwmLight);
      if (periodSeenLast) begin
        if (trackValid) checkOutput("pwm_high_count", highCnt, highCountOf(curDuty));
        highCnt = 0;
        curDuty = pendingDuty;
        trackValid = 1'b1;
        periodSeenLast = 1'b0;
      end
      if (periodPulse) begin
        if (lastPeriodCyc >= 0) checkOutput("period_spacing", cyc - lastPeriodCyc, PERIOD * CLK_DIV);
        lastPeriodCyc = cyc;
        modelActive = nextActive(modelActive, dutyOf(modelLevel));
        pendingDuty = modelActive;
        periodSeenLast = 1'b1;
      end
    end
  end

  initial begin
    int r;
    int waitCnt;
    int highs;

    // Reset held with buttons toggling: everything stays at zero.
    rstN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      buttons = 3'($urandom_range(0, 7));
      @(negedge clk);
      checkOutput("reset_level", int'(level), 0);
      checkOutput("reset_pwm", int'(pwmLight), 0);
      checkOutput("reset_period", int'(periodPulse), 0);
    end
    buttons = 3'b000;
    @(negedge clk);
    rstN = 1'b1;
    monEn = 1'b1;

    // Directed opening: two ups, a bounce, saturation, priority cases.
    applyStimulus(3'b001, 1'b0, DEB + 24);
    applyStimulus(3'b001, 1'b0, DEB + 24);
    applyStimulus(3'b001, 1'b1, DEB + 10);
    for (int i = 0; i < 6; i++) applyStimulus(3'b001, 1'b0, DEB + 10);
    applyStimulus(3'b010, 1'b0, DEB + 12);
    applyStimulus(3'b011, 1'b0, DEB + 20);
    applyStimulus(3'b110, 1'b0, DEB + 40);

    // Randomised commands, weighted toward up presses so high levels occur.
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      applyStimulus(3'($urandom_range(1, 7)), 1'b1, DEB + 8 + $urandom_range(0, 8));
      else if (r < 55) applyStimulus(3'b001, 1'b0, DEB + 8 + $urandom_range(0, 20));
      else if (r < 75) applyStimulus(3'b010, 1'b0, DEB + 8 + $urandom_range(0, 20));
      else if (r < 80) applyStimulus(3'b100, 1'b0, DEB + 8 + $urandom_range(0, 20));
      else             applyStimulus(3'($urandom_range(3, 7)), 1'b0, DEB + 8 + $urandom_range(0, 20));
    end

    applyStimulus(3'b001, 1'b0, DEB + 20);
    checkOutput("pending_events", expQ.size(), 0);

    // Reset in the middle of a period with a non-zero level.
    waitCnt = 0;
    while (!periodPulse && waitCnt < 3 * PERIOD) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("period_seen", int'(periodPulse), 1);
    repeat (5) @(negedge clk);
    monEn = 1'b0;
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_level", int'(level), 0);
    checkOutput("mid_reset_pwm", int'(pwmLight), 0);
    checkOutput("mid_reset_period", int'(periodPulse), 0);
    rstN = 1'b1;

    // Counter restarts from zero: first wrap is PERIOD-1 cycles later, dark.
    waitCnt = 0;
    highs = 0;
    while (waitCnt < 3 * PERIOD) begin
      @(negedge clk);
      waitCnt++;
      highs += int'(pwmLight);
      if (periodPulse) break;
    end
    checkOutput("reset_to_period", waitCnt, PERIOD - 1);
    checkOutput("post_reset_pwm", highs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
